// File: rtl/dec_seq_pkg.sv
// Shared types and constants for the decoder code sequencer.
package dec_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    localparam int DIV_DEFAULT = 25_000_000;

endpackage

// File: rtl/dec_seq_prescaler.sv
// Free-running divider that pulses tick on the cycle its count reaches DIV-1.
module dec_seq_prescaler
    import dec_seq_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Count register; clear beats enable so a state change always restarts the period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= {CW{1'b0}};
        end else if (clr) begin
            cnt <= {CW{1'b0}};
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= {CW{1'b0}};
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/dec_code_sequencer.sv
// Generates the decoder's binary code and enable from start/stop/step buttons,
// auto-advancing at a prescaled rate in RUN and single-stepping in PAUSE.
module dec_code_sequencer
    import dec_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             dir,
    output logic [WIDTH-1:0] binary_out,
    output logic             enable_out,
    output logic             code_tick
);

    state_t state, state_next;
    logic   start_d, stop_d, step_d;
    logic   start_e, stop_e, step_e;
    logic   adv, clear_code, pre_clr, pre_en, pre_tick;

    assign start_e = start & ~start_d;
    assign stop_e  = stop  & ~stop_d;
    assign step_e  = step  & ~step_d;

    // Stop in RUN removes the enable so a coincident prescaler tick cannot advance
    assign pre_en  = (state == RUN) & ~stop_e;
    assign pre_clr = (state_next != state);

    dec_seq_prescaler #(.DIV(DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .en   (pre_en),
        .tick (pre_tick)
    );

    // Button history registers for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_d <= 1'b0;
            stop_d  <= 1'b0;
            step_d  <= 1'b0;
        end else begin
            start_d <= start;
            stop_d  <= stop;
            step_d  <= step;
        end
    end

    // Next-state and advance decode; stop outranks start outranks step
    always_comb begin
        state_next = state;
        adv        = 1'b0;
        clear_code = 1'b0;
        case (state)
            IDLE: begin
                if (start_e) begin
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (stop_e) begin
                    state_next = PAUSE;
                end else if (pre_tick) begin
                    adv = 1'b1;
                end else begin
                    state_next = RUN;
                end
            end
            PAUSE: begin
                if (stop_e) begin
                    state_next = IDLE;
                    clear_code = 1'b1;
                end else if (start_e) begin
                    state_next = RUN;
                end else if (step_e) begin
                    adv = 1'b1;
                end else begin
                    state_next = PAUSE;
                end
            end
            default: begin
                state_next = IDLE;
                clear_code = 1'b1;
            end
        endcase
    end

    // State, code and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            binary_out <= {WIDTH{1'b0}};
            enable_out <= 1'b0;
            code_tick  <= 1'b0;
        end else begin
            state      <= state_next;
            enable_out <= (state_next != IDLE);
            code_tick  <= adv;
            if (clear_code) begin
                binary_out <= {WIDTH{1'b0}};
            end else if (adv) begin
                binary_out <= dir ? (binary_out - WIDTH'(1)) : (binary_out + WIDTH'(1));
            end else begin
                binary_out <= binary_out;
            end
        end
    end

endmodule

// File: tb/tb_dec_code_sequencer.sv
// Directed self-checking bench for dec_code_sequencer with DIV=4, WIDTH=4.
module tb_dec_code_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop, step, dir;
    logic [3:0] binary_out;
    logic       enable_out, code_tick;

    int errors = 0;
    int checks = 0;
    int ticks;
    logic [3:0] exp_code;

    dec_code_sequencer #(.WIDTH(4), .DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .dir        (dir),
        .binary_out (binary_out),
        .enable_out (enable_out),
        .code_tick  (code_tick)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] b, input logic en, input logic tk);
        chk({tag, "_bin"}, 32'(binary_out), 32'(b));
        chk({tag, "_en"},  32'(enable_out), 32'(en));
        chk({tag, "_tick"}, 32'(code_tick), 32'(tk));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; dir = 1'b0;

        // 1. reset and idle hold
        repeat (3) cyc();
        chk_out("reset", 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk_out("idle_hold", 4'd0, 1'b0, 1'b0);
        end

        // 2. up-count lap
        start = 1'b1; cyc(); start = 1'b0;
        chk_out("start_up", 4'd0, 1'b1, 1'b0);
        repeat (3) cyc();
        chk_out("pre_first", 4'd0, 1'b1, 1'b0);
        cyc();
        chk_out("first_adv", 4'd1, 1'b1, 1'b1);
        ticks = 1;
        exp_code = 4'd1;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if ((i % 4) == 3) exp_code = exp_code + 4'd1;
            chk_out("lap", exp_code, 1'b1, ((i % 4) == 3) ? 1'b1 : 1'b0);
            if (code_tick) ticks++;
        end
        chk("lap_ticks", 32'(ticks), 32'd16);
        chk("lap_wrap", 32'(binary_out), 32'd0);

        // back to IDLE: RUN -> PAUSE -> IDLE
        stop = 1'b1; cyc(); stop = 1'b0;
        chk_out("to_pause", 4'd0, 1'b1, 1'b0);
        cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        chk_out("to_idle", 4'd0, 1'b0, 1'b0);

        // 3. down count with wrap, then dir flip
        dir = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (4) cyc();
        chk_out("down_wrap", 4'd15, 1'b1, 1'b1);
        repeat (4) cyc();
        chk_out("down_14", 4'd14, 1'b1, 1'b1);
        dir = 1'b0;
        repeat (4) cyc();
        chk_out("dir_flip", 4'd15, 1'b1, 1'b1);

        // 4. pause hold and stepping
        stop = 1'b1; cyc(); stop = 1'b0;
        chk_out("pause", 4'd15, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk_out("pause_hold", 4'd15, 1'b1, 1'b0);
        end
        exp_code = 4'd15;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; cyc(); step = 1'b0;
            exp_code = exp_code + 4'd1;
            chk_out("step", exp_code, 1'b1, 1'b1);
            cyc();
            chk_out("step_gap", exp_code, 1'b1, 1'b0);
        end
        step = 1'b1;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (code_tick) ticks++;
        end
        step = 1'b0;
        cyc();
        if (code_tick) ticks++;
        chk("step_held_ticks", 32'(ticks), 32'd1);
        chk("step_held_bin", 32'(binary_out), 32'd3);

        // 5. start+stop together in PAUSE -> IDLE, cleared without a tick
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        chk_out("pause_clear", 4'd0, 1'b0, 1'b0);
        cyc();
        chk_out("pause_clear2", 4'd0, 1'b0, 1'b0);
        // stop coincident with the prescaler tick
        start = 1'b1; cyc(); start = 1'b0;
        repeat (3) cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        chk_out("stop_on_tick", 4'd0, 1'b1, 1'b0);
        repeat (6) cyc();
        chk_out("stop_on_tick_hold", 4'd0, 1'b1, 1'b0);

        // 6. step to 9, run, then asynchronous reset mid-cycle
        for (int i = 0; i < 9; i++) begin
            step = 1'b1; cyc(); step = 1'b0; cyc();
        end
        chk_out("at_nine", 4'd9, 1'b1, 1'b0);
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        chk_out("run_nine", 4'd9, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_out("async_rst", 4'd0, 1'b0, 1'b0);
        cyc(); cyc();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_out("post_rst_idle", 4'd0, 1'b0, 1'b0);
        end
        start = 1'b1; cyc(); start = 1'b0;
        chk_out("restart", 4'd0, 1'b1, 1'b0);
        repeat (4) cyc();
        chk_out("restart_adv", 4'd1, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
